// File: rtl/game_pkg.sv
// Shared game constants: button bit positions, default conditioner timing,
// and the per-button repeat FSM state encoding.
package game_pkg;

  localparam int unsigned NUM_BTN   = 4;
  localparam int unsigned BTN_UP    = 0;
  localparam int unsigned BTN_DOWN  = 1;
  localparam int unsigned BTN_LEFT  = 2;
  localparam int unsigned BTN_RIGHT = 3;

  // 10 ms / 250 ms / 100 ms at the 25 MHz divided pixel clock
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 250000;
  localparam int unsigned DEF_REPEAT_DELAY    = 6250000;
  localparam int unsigned DEF_REPEAT_PERIOD   = 2500000;

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_HOLD   = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_e;

endpackage

// File: rtl/btn_channel.sv
// One button: 2-FF synchronizer, debounce, rising-edge detect and repeat FSM.
// Exposes next-cycle level/move so the top can register the cancelled moves.
module btn_channel
  import game_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic level,
  output logic press,
  output logic level_nxt_c,
  output logic move_nxt_c
);

  localparam int unsigned DW   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RW   = $clog2(RMAX) + 1;

  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);

  logic          s1, s2;
  logic [DW-1:0] dcnt, dcnt_n;
  logic          level_n;
  logic          press_n;
  rpt_state_e    state, state_n;
  logic [RW-1:0] rcnt, rcnt_n;

  // Synchronizer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn;
      s2 <= s1;
    end
  end

  // Debounce: level toggles only after DEBOUNCE_CYCLES consecutive differing cycles
  always_comb begin
    level_n = level;
    dcnt_n  = '0;
    if (s2 != level) begin
      if (dcnt == DEB_LAST) level_n = ~level;
      else                  dcnt_n  = dcnt + DW'(1);
    end
  end

  assign press_n     = level_n & ~level;
  assign level_nxt_c = level_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dcnt  <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      dcnt  <= dcnt_n;
      level <= level_n;
      press <= press_n;
    end
  end

  // Repeat FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RPT_IDLE;
      rcnt  <= '0;
    end else begin
      state <= state_n;
      rcnt  <= rcnt_n;
    end
  end

  // Next state from this cycle, then the move pulse that next cycle will carry
  always_comb begin
    state_n    = state;
    rcnt_n     = rcnt;
    move_nxt_c = 1'b0;
    case (state)
      RPT_IDLE: begin
        if (press) begin
          state_n = RPT_HOLD;
          rcnt_n  = '0;
        end
      end
      RPT_HOLD: begin
        if (!level) begin
          state_n = RPT_IDLE;
          rcnt_n  = '0;
        end else if (rcnt == DLY_LAST) begin
          state_n = RPT_REPEAT;
          rcnt_n  = '0;
        end else begin
          rcnt_n = rcnt + RW'(1);
        end
      end
      RPT_REPEAT: begin
        if (!level) begin
          state_n = RPT_IDLE;
          rcnt_n  = '0;
        end else if (rcnt == PER_LAST) begin
          rcnt_n = '0;
        end else begin
          rcnt_n = rcnt + RW'(1);
        end
      end
      default: begin
        state_n = RPT_IDLE;
        rcnt_n  = '0;
      end
    endcase

    case (state_n)
      RPT_IDLE:   move_nxt_c = press_n;
      RPT_HOLD:   move_nxt_c = level_n && (rcnt_n == DLY_LAST);
      RPT_REPEAT: move_nxt_c = level_n && (rcnt_n == PER_LAST);
      default:    move_nxt_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/btn_conditioner.sv
// Four-button input conditioner: debounced levels, press pulses and
// hold-to-repeat move pulses with opposing-direction cancel.
module btn_conditioner
  import game_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_in,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_move
);

  logic [NUM_BTN-1:0] level_nxt;
  logic [NUM_BTN-1:0] move_nxt;
  logic [NUM_BTN-1:0] cancel_nxt;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    btn_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .btn        (btn_in[i]),
      .level      (btn_level[i]),
      .press      (btn_press[i]),
      .level_nxt_c(level_nxt[i]),
      .move_nxt_c (move_nxt[i])
    );
  end

  // Opposing pairs held together suppress both moves; FSMs keep running
  always_comb begin
    cancel_nxt = '0;
    if (level_nxt[BTN_UP] && level_nxt[BTN_DOWN]) begin
      cancel_nxt[BTN_UP]   = 1'b1;
      cancel_nxt[BTN_DOWN] = 1'b1;
    end
    if (level_nxt[BTN_LEFT] && level_nxt[BTN_RIGHT]) begin
      cancel_nxt[BTN_LEFT]  = 1'b1;
      cancel_nxt[BTN_RIGHT] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) btn_move <= '0;
    else        btn_move <= move_nxt & ~cancel_nxt;
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner: per-cycle expectations queued from the
// timing rules, then popped and checked one cycle at a time.
module tb_btn_conditioner;

  localparam int DEB = 4;
  localparam int DLY = 10;
  localparam int PER = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] btn_in = 4'h0;
  logic [3:0] btn_level, btn_press, btn_move;

  typedef struct packed {
    logic [3:0] level;
    logic [3:0] press;
    logic [3:0] move;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  btn_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY   (DLY),
    .REPEAT_PERIOD  (PER)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_in   (btn_in),
    .btn_level(btn_level),
    .btn_press(btn_press),
    .btn_move (btn_move)
  );

  // Move due at press cycle t, at t+DLY, then every PER cycles
  function automatic logic rep_due(input int n, input int t);
    return (n == t) || ((n >= t + DLY) && (((n - t - DLY) % PER) == 0));
  endfunction

  task automatic push(input int cnt, input logic [3:0] l, input logic [3:0] p, input logic [3:0] m);
    exp_t e;
    e.level = l;
    e.press = p;
    e.move  = m;
    repeat (cnt) sb.push_back(e);
  endtask

  task automatic check_now(input string tag, input exp_t e);
    n_assert++;
    assert (btn_level === e.level) else begin
      n_fail++;
      $error("FAIL %s btn_level observed=%h expected=%h", tag, btn_level, e.level);
    end
    n_assert++;
    assert (btn_press === e.press) else begin
      n_fail++;
      $error("FAIL %s btn_press observed=%h expected=%h", tag, btn_press, e.press);
    end
    n_assert++;
    assert (btn_move === e.move) else begin
      n_fail++;
      $error("FAIL %s btn_move observed=%h expected=%h", tag, btn_move, e.move);
    end
  endtask

  task automatic step(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL %s scoreboard empty observed=%h expected=entry", tag, btn_level);
    end else begin
      e = sb.pop_front();
      check_now(tag, e);
    end
  endtask

  initial begin
    logic lv, l0, l1, m0;
    exp_t zero;
    zero = '0;

    // Reset with all buttons held: outputs stay 0
    btn_in = 4'hF;
    push(3, 4'h0, 4'h0, 4'h0);
    repeat (3) step("reset_hold");

    // Release reset: all levels rise at edge 6, moves cancelled in both pairs
    rst_n = 1'b1;
    for (int n = 1; n <= 24; n++) begin
      lv = (n >= 6) && (n <= 20);
      push(1, {4{lv}}, (n == 6) ? 4'hF : 4'h0, 4'h0);
    end
    for (int n = 1; n <= 24; n++) begin
      step("reset_release");
      if (n == 15) btn_in = 4'h0;
    end

    // Glitch of 3 cycles on up is rejected
    btn_in = 4'h1;
    push(12, 4'h0, 4'h0, 4'h0);
    for (int n = 1; n <= 12; n++) begin
      step("glitch");
      if (n == 3) btn_in = 4'h0;
    end

    // Clean press on left, released before the first repeat
    btn_in = 4'h4;
    for (int n = 1; n <= 18; n++) begin
      lv = (n >= 6) && (n <= 13);
      push(1, {1'b0, lv, 2'b0}, {1'b0, n == 6, 2'b0}, {1'b0, lv && rep_due(n, 6), 2'b0});
    end
    for (int n = 1; n <= 18; n++) begin
      step("clean_press");
      if (n == 8) btn_in = 4'h0;
    end

    // Auto-repeat on right: t, t+10, t+13, ... then stop on release
    btn_in = 4'h8;
    for (int n = 1; n <= 45; n++) begin
      lv = (n >= 6) && (n <= 41);
      push(1, {lv, 3'b0}, {n == 6, 3'b0}, {lv && rep_due(n, 6), 3'b0});
    end
    for (int n = 1; n <= 45; n++) begin
      step("auto_repeat");
      if (n == 36) btn_in = 4'h0;
    end

    // Opposing cancel: up held, down added then released
    btn_in = 4'h1;
    for (int n = 1; n <= 45; n++) begin
      l0 = (n >= 6) && (n <= 40);
      l1 = (n >= 13) && (n <= 25);
      m0 = l0 && !(l0 && l1) && rep_due(n, 6);
      push(1, {2'b0, l1, l0}, {2'b0, n == 13, n == 6}, {3'b0, m0});
    end
    for (int n = 1; n <= 45; n++) begin
      step("opposing");
      if (n == 7)  btn_in = 4'h3;
      if (n == 20) btn_in = 4'h1;
      if (n == 35) btn_in = 4'h0;
    end

    // Mid-hold reset while in REPEAT, then a fresh press after release
    btn_in = 4'h8;
    for (int n = 1; n <= 20; n++) begin
      push(1, {n >= 6, 3'b0}, {n == 6, 3'b0}, {rep_due(n, 6), 3'b0});
    end
    for (int n = 1; n <= 20; n++) step("pre_reset_hold");
    #3;
    rst_n = 1'b0;
    #1;
    check_now("async_reset", zero);
    push(2, 4'h0, 4'h0, 4'h0);
    repeat (2) step("mid_reset");
    rst_n = 1'b1;
    for (int n = 1; n <= 14; n++) begin
      lv = (n >= 6) && (n <= 13);
      push(1, {lv, 3'b0}, {n == 6, 3'b0}, {n == 6, 3'b0});
    end
    for (int n = 1; n <= 14; n++) begin
      step("re_press");
      if (n == 8) btn_in = 4'h0;
    end

    n_assert++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
